// File: rtl/fir_decimator.sv
// fir_decimator: keeps one sample in every DECIM from the FIR output stream and
// buffers the kept samples in a first-word-fall-through FIFO. The FIFO drives a
// valid/ready output and reports its fill level and a sticky overflow flag.
// Define FIR_DECIM_AVG_EN to push the boxcar average of each DECIM-sample group
// instead of the last sample of the group.
module fir_decimator #(
    parameter int unsigned WD    = 24,
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WD-1:0]                din,
    input  logic                         din_valid,
    output logic [WD-1:0]                dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int unsigned PW   = $clog2(DECIM);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned LW   = $clog2(DEPTH + 1);

    logic [PW-1:0]   phase_q, phase_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            valid_q, valid_d;
    logic [WD-1:0]   dout_q, dout_d;
    logic            ovf_q, ovf_d;
    logic [WD-1:0]   mem_q [DEPTH];

    logic            push_req_c;
    logic            pop_c;
    logic            full_c;
    logic            push_c;
    logic [WD-1:0]   push_data_c;

    // Last valid sample of a phase cycle requests a push; a pop frees a slot
    // in the same cycle, so a full FIFO still accepts a push while popping.
    assign push_req_c = din_valid && (phase_q == PW'(DECIM - 1));
    assign pop_c      = valid_q && dout_ready;
    assign full_c     = (level_q == LW'(DEPTH));
    assign push_c     = push_req_c && (!full_c || pop_c);

`ifdef FIR_DECIM_AVG_EN
    localparam int unsigned AW = WD + PW;

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] din_ext_c;
    logic signed [AW-1:0] sum_c;

    // Boxcar sum of the group; the floor-divided total is the pushed sample.
    always_comb begin
        din_ext_c   = {{PW{din[WD-1]}}, din};
        sum_c       = acc_q + din_ext_c;
        push_data_c = WD'(sum_c >>> PW);
        acc_d       = acc_q;
        if (din_valid) begin
            acc_d = push_req_c ? '0 : sum_c;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign push_data_c = din;
`endif

    // Next-state for phase counter, FIFO pointers, level, head register and flags.
    always_comb begin
        phase_d  = phase_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;

        if (din_valid) begin
            phase_d = phase_q + PW'(1);
        end
        if (push_req_c && full_c && !pop_c) begin
            ovf_d = 1'b1;
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end

        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        valid_d = (level_d != '0);

        // The pushed sample becomes the head when nothing else remains;
        // otherwise a pop exposes the next stored entry.
        if (push_c && (level_q == LW'(pop_c))) begin
            dout_d = push_data_c;
        end else if (pop_c && (level_q != LW'(1))) begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem_q[wr_ptr_q] <= push_data_c;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign level      = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Testbench for fir_decimator: table of directed vectors plus hand-written
// sequences for overflow, backpressure on a full FIFO and mid-run reset.
module tb_fir_decimator;

    localparam int unsigned WD = 24;

`ifdef FIR_DECIM_AVG_EN
    localparam int OFS  = 1;   // group average of a ramp = last sample - 2
    localparam int EXP3 = 11;  // floor((10+11+12+13)/4)
`else
    localparam int OFS  = 3;   // last sample of the group
    localparam int EXP3 = 13;
`endif

    logic          clk;
    logic          rst;
    logic [WD-1:0] din;
    logic          din_valid;
    logic [WD-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [3:0]    level;
    logic          overflow;

    int n_cmp;
    int n_bad;

    fir_decimator #(.WD(24), .DECIM(4), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst;
        logic [WD-1:0] din;
        logic          vld;
        logic          rdy;
        logic          e_valid;
        logic [WD-1:0] e_dout;
        logic [3:0]    e_level;
        logic          e_ovf;
        logic          chk_dout;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Drive on the falling edge, sample just after the following rising edge.
    task automatic step(input logic r, input logic [WD-1:0] d, input logic v, input logic rd);
        @(negedge clk);
        rst        = r;
        din        = d;
        din_valid  = v;
        dout_ready = rd;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input string nm, input logic r, input logic [WD-1:0] d,
                                input logic v, input logic rd, input logic ev,
                                input logic [WD-1:0] ed, input logic [3:0] el,
                                input logic eo, input logic cd);
        vec_t t;
        t.name = nm; t.rst = r; t.din = d; t.vld = v; t.rdy = rd;
        t.e_valid = ev; t.e_dout = ed; t.e_level = el; t.e_ovf = eo; t.chk_dout = cd;
        tbl.push_back(t);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int n;
        logic rdy;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;

        // ---------------- table: reset, basic, negative, gaps ----------------
        add("reset", 1, 24'h0, 0, 0, 0, 24'h0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            logic hit;
            hit = (i % 4 == 3);
            add("basic", 0, 24'(i), 1, 1, hit, 24'(i - 3 + OFS), hit ? 4'd1 : 4'd0, 0, hit);
        end
        for (int i = 0; i < 4; i++)
            add("neg_ones", 0, 24'hFFFFFF, 1, 1, i == 3, 24'hFFFFFF, (i == 3) ? 4'd1 : 4'd0, 0, i == 3);
        for (int i = 0; i < 4; i++)
            add("neg_min", 0, 24'h800000, 1, 1, i == 3, 24'h800000, (i == 3) ? 4'd1 : 4'd0, 0, i == 3);
        add("gap", 0, 24'd10, 1, 1, 0, 24'h0, 0, 0, 0);
        add("gap", 0, 24'd99, 0, 1, 0, 24'h0, 0, 0, 0);
        add("gap", 0, 24'd99, 0, 1, 0, 24'h0, 0, 0, 0);
        add("gap", 0, 24'd11, 1, 1, 0, 24'h0, 0, 0, 0);
        add("gap", 0, 24'd99, 0, 1, 0, 24'h0, 0, 0, 0);
        add("gap", 0, 24'd99, 0, 1, 0, 24'h0, 0, 0, 0);
        add("gap", 0, 24'd12, 1, 1, 0, 24'h0, 0, 0, 0);
        add("gap", 0, 24'd99, 0, 1, 0, 24'h0, 0, 0, 0);
        add("gap", 0, 24'd99, 0, 1, 0, 24'h0, 0, 0, 0);
        add("gap", 0, 24'd13, 1, 1, 1, 24'(EXP3), 1, 0, 1);
        add("gap_idle", 0, 24'd99, 0, 1, 0, 24'h0, 0, 0, 0);
        add("gap_idle", 0, 24'd99, 0, 1, 0, 24'h0, 0, 0, 0);

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].din, tbl[k].vld, tbl[k].rdy);
            check({tbl[k].name, "_valid"}, int'(dout_valid), int'(tbl[k].e_valid));
            check({tbl[k].name, "_level"}, int'(level), int'(tbl[k].e_level));
            check({tbl[k].name, "_ovf"}, int'(overflow), int'(tbl[k].e_ovf));
            if (tbl[k].chk_dout)
                check({tbl[k].name, "_dout"}, int'(dout), int'(tbl[k].e_dout));
        end

        // ---------------- overflow with a stalled consumer ----------------
        step(1, '0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 24'(i), 1, 0);
            n = (i + 1) / 4;
            check("ovf_level", int'(level), (n > 8) ? 8 : n);
            check("ovf_flag", int'(overflow), (n >= 9) ? 1 : 0);
            check("ovf_valid", int'(dout_valid), (n > 0) ? 1 : 0);
            if (n > 0) check("ovf_hold", int'(dout), OFS);
        end
        for (int k = 0; k < 8; k++) begin
            check("drain_valid", int'(dout_valid), 1);
            check("drain_dout", int'(dout), 4 * k + OFS);
            step(0, '0, 0, 1);
        end
        check("drain_empty", int'(dout_valid), 0);
        check("drain_level", int'(level), 0);
        check("drain_ovf_sticky", int'(overflow), 1);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 8; i++) step(0, 24'(i), 1, 0);
        step(0, 24'd1, 1, 0);
        step(0, 24'd2, 1, 0);
        check("mid_level", int'(level), 2);
        step(1, '0, 0, 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_dout", int'(dout), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 24'(100 + i), 1, 1);
            check("post_rst_valid", int'(dout_valid), (i == 3) ? 1 : 0);
            if (i == 3) check("post_rst_dout", int'(dout), 100 - 3 + OFS + 3);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, '0, 0, 1);
            check("post_rst_idle", int'(dout_valid), 0);
        end

        // ---------------- backpressure on a full FIFO ----------------
        step(1, '0, 0, 0);
        q.delete();
        for (int i = 0; i < 64; i++) begin
            rdy = (i < 35) ? 1'b0 : 1'(i % 2);
            if (rdy && q.size() > 0) begin
                check("bp_order", int'(dout), q[0]);
                void'(q.pop_front());
            end
            if (i % 4 == 3) begin
                if (q.size() < 8) q.push_back(i - 3 + OFS);
            end
            step(0, 24'(i), 1, rdy);
            check("bp_level", int'(level), q.size());
            check("bp_valid", int'(dout_valid), (q.size() > 0) ? 1 : 0);
            check("bp_ovf", int'(overflow), 0);
        end
        for (int k = 0; k < 12 && q.size() > 0; k++) begin
            check("bp_drain", int'(dout), q[0]);
            void'(q.pop_front());
            step(0, '0, 0, 1);
        end
        check("bp_drained", q.size(), 0);
        check("bp_final_valid", int'(dout_valid), 0);
        check("bp_final_ovf", int'(overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
